bht_predictor: RTL

- Branch history table that answers the fetch stage's per-cycle PC with a taken/not-taken prediction and a predicted target.
- Drives the fetch stage's `pc_ld_bht` / `bht_pc_new` pair.
- Trained by branch resolution from the execute stage, which is the producer of `wtg` redirects.
- Direct-mapped, tagged, 2-bit saturating counters; lookup is combinational, training is sequential.

---
 rtl/bht_predictor_if.sv | 36 +++
 rtl/bht_predictor.sv | 110 +++++++++++
 2 files changed

// File: rtl/bht_predictor_if.sv
// Fetch/execute-facing bundle of the branch history table: lookup, training and
// optional statistics (present only when BHT_STAT_EN is defined).
interface bht_predictor_if #(
  parameter int ADDR_NBIT = 12
);
  logic                 en;
  logic [ADDR_NBIT-1:0] pc;
  logic                 pred_taken;
  logic [ADDR_NBIT-1:0] pred_target;
  logic                 upd_valid;
  logic [ADDR_NBIT-1:0] upd_pc;
  logic                 upd_taken;
  logic [ADDR_NBIT-1:0] upd_target;
`ifdef BHT_STAT_EN
  logic [15:0]          stat_upd_cnt;
  logic [15:0]          stat_correct_cnt;

  modport master (
    output en, pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_taken, pred_target, stat_upd_cnt, stat_correct_cnt
  );
  modport slave (
    input  en, pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_taken, pred_target, stat_upd_cnt, stat_correct_cnt
  );
`else
  modport master (
    output en, pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_taken, pred_target
  );
  modport slave (
    input  en, pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_taken, pred_target
  );
`endif
endinterface

// File: rtl/bht_predictor.sv
// Direct-mapped, tagged branch history table with 2-bit saturating counters.
// Combinational lookup, registered training. BHT_STAT_EN adds update/correct counters.
module bht_predictor #(
  parameter int ADDR_NBIT = 12,
  parameter int IDX_NBIT  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bht_predictor_if.slave  bus
);
  localparam int NENT     = 1 << IDX_NBIT;
  localparam int TAG_NBIT = ADDR_NBIT - IDX_NBIT - 2;

  logic                 valid_q  [NENT];
  logic [TAG_NBIT-1:0]  tag_q    [NENT];
  logic [ADDR_NBIT-1:0] target_q [NENT];
  logic [1:0]           ctr_q    [NENT];

  logic [IDX_NBIT-1:0]  lk_idx;
  logic [TAG_NBIT-1:0]  lk_tag;
  logic                 lk_taken;

  assign lk_idx   = bus.pc[IDX_NBIT+1:2];
  assign lk_tag   = bus.pc[ADDR_NBIT-1:IDX_NBIT+2];
  assign lk_taken = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];

  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target_q[lk_idx] : '0;

  logic [IDX_NBIT-1:0]  upd_idx;
  logic [TAG_NBIT-1:0]  upd_tag;
  logic                 upd_apply;
  logic                 upd_hit;
  logic                 upd_pred;
  logic                 ent_we;
  logic                 ent_valid_d;
  logic [TAG_NBIT-1:0]  ent_tag_d;
  logic [ADDR_NBIT-1:0] ent_target_d;
  logic [1:0]           ent_ctr_d;

  assign upd_idx   = bus.upd_pc[IDX_NBIT+1:2];
  assign upd_tag   = bus.upd_pc[ADDR_NBIT-1:IDX_NBIT+2];
  assign upd_apply = bus.en && bus.upd_valid;
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_pred  = upd_hit && ctr_q[upd_idx][1];

  always_comb begin
    ent_we       = 1'b0;
    ent_valid_d  = valid_q[upd_idx];
    ent_tag_d    = tag_q[upd_idx];
    ent_target_d = target_q[upd_idx];
    ent_ctr_d    = ctr_q[upd_idx];
    if (upd_apply) begin
      if (upd_hit) begin
        ent_we = 1'b1;
        if (bus.upd_taken) begin
          ent_ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
          ent_target_d = bus.upd_target;
        end else begin
          ent_ctr_d    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        // Never-taken branches stay out of the table; only taken misses allocate.
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = upd_tag;
        ent_target_d = bus.upd_target;
        ent_ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (ent_we) begin
      valid_q[upd_idx]  <= ent_valid_d;
      tag_q[upd_idx]    <= ent_tag_d;
      target_q[upd_idx] <= ent_target_d;
      ctr_q[upd_idx]    <= ent_ctr_d;
    end
  end

`ifdef BHT_STAT_EN
  logic [15:0] stat_upd_cnt_q;
  logic [15:0] stat_correct_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd_cnt_q     <= '0;
      stat_correct_cnt_q <= '0;
    end else if (upd_apply) begin
      stat_upd_cnt_q <= stat_upd_cnt_q + 16'd1;
      if (upd_pred == bus.upd_taken)
        stat_correct_cnt_q <= stat_correct_cnt_q + 16'd1;
    end
  end

  assign bus.stat_upd_cnt     = stat_upd_cnt_q;
  assign bus.stat_correct_cnt = stat_correct_cnt_q;
`else
  logic unused_upd_pred;
  assign unused_upd_pred = upd_pred;
`endif
endmodule
